// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush and instruction-RAM freeze.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       idRx,
    input  logic [2:0]       idRy,
    input  logic             idUsesRx,
    input  logic             idUsesRy,
    input  logic [1:0]       exMemRead,
    input  logic             exRegWrite,
    input  logic [2:0]       exDstReg,
    input  logic             exBranchTaken,
    input  logic             exJump,
    input  logic             memInstrSpace,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             idexHold,
    output logic             exmemHold
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic [CNT_W-1:0] freezeCount
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_t;

    // Counter holds the number of FREEZE cycles still to come after the entry cycle.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     stateReg, stateNext;
    logic [3:0] waitCntReg, waitCntNext;

    logic loadUse;
    logic redirect;
    logic freezeNow;
    logic flushNow;
    logic stallNow;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateReg   <= RUN;
            waitCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
        end
    end

    always_comb begin
        loadUse = (exMemRead != 2'd0) && exRegWrite &&
                  ((idUsesRx && (idRx == exDstReg)) || (idUsesRy && (idRy == exDstReg)));
        redirect    = exBranchTaken | exJump;
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        freezeNow   = 1'b0;
        flushNow    = 1'b0;
        stallNow    = 1'b0;

        case (stateReg)
            RUN: begin
                if (memInstrSpace) begin
                    freezeNow = 1'b1;
                    if (MEM_WAIT > 1) begin
                        stateNext   = FREEZE;
                        waitCntNext = WAIT_LOAD;
                    end
                end else if (redirect) begin
                    flushNow = 1'b1;
                end else if (loadUse) begin
                    stallNow = 1'b1;
                end
            end
            FREEZE: begin
                // memInstrSpace is deliberately ignored here; the held MEM stage re-presents it.
                freezeNow = 1'b1;
                if (waitCntReg <= 4'd1) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCntReg - 4'd1;
                end
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        idexHold   = 1'b0;
        exmemHold  = 1'b0;
        if (RST) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (freezeNow) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexHold  = 1'b1;
            exmemHold = 1'b1;
        end else if (flushNow) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (stallNow) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] statReg  [3];
    logic             statInc  [3];

    assign statInc[0] = stallNow;
    assign statInc[1] = flushNow;
    assign statInc[2] = freezeNow;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    statReg[gi] <= '0;
                end else if (statInc[gi] && (statReg[gi] != {CNT_W{1'b1}})) begin
                    statReg[gi] <= statReg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stallCount  = statReg[0];
    assign flushCount  = statReg[1];
    assign freezeCount = statReg[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with MEM_WAIT = 1, 2, 3 share the stimulus.
// Statistics checks run when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

    localparam int NORMAL = 6'b110000;
    localparam int STALL  = 6'b000100;
    localparam int REDIR  = 6'b111100;
    localparam int FRZ    = 6'b000011;
    localparam int RSTV   = 6'b001100;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] idRx = '0, idRy = '0;
    logic       idUsesRx = 1'b0, idUsesRy = 1'b0;
    logic [1:0] exMemRead = '0;
    logic       exRegWrite = 1'b0;
    logic [2:0] exDstReg = '0;
    logic       exBranchTaken = 1'b0, exJump = 1'b0, memInstrSpace = 1'b0;

    logic pcW [4];
    logic ifW [4];
    logic flW [4];
    logic bbW [4];
    logic ihW [4];
    logic ehW [4];
`ifdef HAZARD_STATS_EN
    logic [3:0] stallC  [4];
    logic [3:0] flushC  [4];
    logic [3:0] freezeC [4];
`endif

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_dut
            hazard_ctrl #(.MEM_WAIT(gi), .CNT_W(4)) dut (
                .CLK(CLK), .RST(RST),
                .idRx(idRx), .idRy(idRy), .idUsesRx(idUsesRx), .idUsesRy(idUsesRy),
                .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDstReg(exDstReg),
                .exBranchTaken(exBranchTaken), .exJump(exJump), .memInstrSpace(memInstrSpace),
                .pcWrite(pcW[gi]), .ifidWrite(ifW[gi]), .ifidFlush(flW[gi]),
                .idexBubble(bbW[gi]), .idexHold(ihW[gi]), .exmemHold(ehW[gi])
`ifdef HAZARD_STATS_EN
                ,
                .stallCount(stallC[gi]), .flushCount(flushC[gi]), .freezeCount(freezeC[gi])
`endif
            );
        end
    endgenerate

    typedef struct {
        logic [2:0] rx;
        logic [2:0] ry;
        logic       usesRx;
        logic       usesRy;
        logic [1:0] memRead;
        logic       regWrite;
        logic [2:0] dst;
        logic       br;
        logic       jmp;
        int         expOut;
    } vec_t;

    vec_t vecs [12];

    function automatic int outs(input int k);
        return int'({pcW[k], ifW[k], flW[k], bbW[k], ihW[k], ehW[k]});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        idRx = '0; idRy = '0; idUsesRx = 1'b0; idUsesRy = 1'b0;
        exMemRead = '0; exRegWrite = 1'b0; exDstReg = '0;
        exBranchTaken = 1'b0; exJump = 1'b0; memInstrSpace = 1'b0;
    endtask

    task automatic setLoadUse();
        idRx = 3'd3; idUsesRx = 1'b1; exMemRead = 2'd1; exRegWrite = 1'b1; exDstReg = 3'd3;
    endtask

    initial begin
        //            rx ry uRx uRy mr rw dst br jmp expected
        vecs[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, NORMAL};
        vecs[1]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd3, 1'b0, 1'b0, STALL};
        vecs[2]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1, 3'd3, 1'b0, 1'b0, NORMAL};
        vecs[3]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd3, 1'b1, 1'b0, REDIR};
        vecs[4]  = '{3'd1, 3'd5, 1'b1, 1'b1, 2'd2, 1'b1, 3'd5, 1'b0, 1'b0, STALL};
        vecs[5]  = '{3'd1, 3'd5, 1'b1, 1'b0, 2'd2, 1'b1, 3'd5, 1'b0, 1'b0, NORMAL};
        vecs[6]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd3, 1'b0, 1'b0, NORMAL};
        vecs[7]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd4, 1'b0, 1'b0, NORMAL};
        vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b1, REDIR};
        vecs[9]  = '{3'd3, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd3, 1'b0, 1'b1, REDIR};
        vecs[10] = '{3'd0, 3'd2, 1'b1, 1'b0, 2'd3, 1'b1, 3'd0, 1'b0, 1'b0, STALL};
        vecs[11] = '{3'd2, 3'd7, 1'b0, 1'b1, 2'd1, 1'b1, 3'd7, 1'b0, 1'b0, STALL};

        // Reset values, before any clock edge
        #2;
        for (int k = 1; k <= 3; k++) chk($sformatf("reset_out_w%0d", k), outs(k), RSTV);
        nextCycle();
        RST = 1'b0;
        #3;
        chk("post_reset_normal", outs(2), NORMAL);

        // Single-cycle combinational vectors, always in RUN
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            idRx = vecs[i].rx; idRy = vecs[i].ry;
            idUsesRx = vecs[i].usesRx; idUsesRy = vecs[i].usesRy;
            exMemRead = vecs[i].memRead; exRegWrite = vecs[i].regWrite; exDstReg = vecs[i].dst;
            exBranchTaken = vecs[i].br; exJump = vecs[i].jmp;
            #3;
            for (int k = 1; k <= 3; k++) chk($sformatf("vec%0d_w%0d", i, k), outs(k), vecs[i].expOut);
        end

        // One-cycle memInstrSpace pulse: freeze length equals MEM_WAIT
        nextCycle(); idle(); memInstrSpace = 1'b1; #3;
        for (int k = 1; k <= 3; k++) chk($sformatf("frz_c0_w%0d", k), outs(k), FRZ);
        nextCycle(); memInstrSpace = 1'b0; #3;
        chk("frz_c1_w1", outs(1), NORMAL);
        chk("frz_c1_w2", outs(2), FRZ);
        chk("frz_c1_w3", outs(3), FRZ);
        nextCycle(); #3;
        chk("frz_c2_w2", outs(2), NORMAL);
        chk("frz_c2_w3", outs(3), FRZ);
        nextCycle(); #3;
        chk("frz_c3_w3", outs(3), NORMAL);

        // Jump held through a freeze: flush only once RUN resumes
        nextCycle(); exJump = 1'b1; memInstrSpace = 1'b1; #3;
        chk("jmpfrz_c0_w2", outs(2), FRZ);
        nextCycle(); memInstrSpace = 1'b0; #3;
        chk("jmpfrz_c1_w1", outs(1), REDIR);
        chk("jmpfrz_c1_w2", outs(2), FRZ);
        nextCycle(); #3;
        chk("jmpfrz_c2_w2", outs(2), REDIR);
        chk("jmpfrz_c2_w3", outs(3), FRZ);
        nextCycle(); #3;
        chk("jmpfrz_c3_w3", outs(3), REDIR);

        // memInstrSpace during FREEZE does not extend the freeze
        nextCycle(); idle(); memInstrSpace = 1'b1; #3;
        chk("ignfrz_c0_w2", outs(2), FRZ);
        nextCycle(); #3;
        chk("ignfrz_c1_w2", outs(2), FRZ);
        nextCycle(); memInstrSpace = 1'b0; #3;
        chk("ignfrz_c2_w2", outs(2), NORMAL);
        chk("ignfrz_c2_w3", outs(3), FRZ);
        nextCycle(); #3;
        chk("ignfrz_c3_w3", outs(3), NORMAL);

        // Load-use held under a freeze is stalled after release
        nextCycle(); setLoadUse(); memInstrSpace = 1'b1; #3;
        chk("lufrz_c0_w2", outs(2), FRZ);
        nextCycle(); memInstrSpace = 1'b0; #3;
        chk("lufrz_c1_w1", outs(1), STALL);
        chk("lufrz_c1_w2", outs(2), FRZ);
        nextCycle(); #3;
        chk("lufrz_c2_w2", outs(2), STALL);

        // Reset asserted in the second freeze cycle aborts the freeze
        nextCycle(); idle(); memInstrSpace = 1'b1; #3;
        chk("rstfrz_c0_w3", outs(3), FRZ);
        nextCycle(); memInstrSpace = 1'b0; #2;
        RST = 1'b1; #1;
        chk("rstfrz_mid_w3", outs(3), RSTV);
        nextCycle(); RST = 1'b0; #3;
        chk("rstfrz_rel_w3", outs(3), NORMAL);
        nextCycle(); #3;
        chk("rstfrz_rel2_w3", outs(3), NORMAL);

`ifdef HAZARD_STATS_EN
        nextCycle(); idle(); RST = 1'b1; #3;
        chk("stat_rst_stall", int'(stallC[2]), 0);
        chk("stat_rst_freeze", int'(freezeC[3]), 0);
        nextCycle(); RST = 1'b0; setLoadUse();
        repeat (20) nextCycle();
        idle();
        #3;
        chk("stat_stall_sat", int'(stallC[2]), 15);
        chk("stat_flush_zero", int'(flushC[2]), 0);
        chk("stat_freeze_zero", int'(freezeC[2]), 0);
        nextCycle(); exBranchTaken = 1'b1;
        nextCycle();
        nextCycle(); exBranchTaken = 1'b0; #3;
        chk("stat_flush_two", int'(flushC[2]), 2);
        nextCycle(); memInstrSpace = 1'b1;
        nextCycle(); memInstrSpace = 1'b0;
        nextCycle();
        nextCycle(); #3;
        chk("stat_freeze_w1", int'(freezeC[1]), 1);
        chk("stat_freeze_w2", int'(freezeC[2]), 2);
        chk("stat_freeze_w3", int'(freezeC[3]), 3);
        chk("stat_stall_keep", int'(stallC[3]), 15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: MEM_WAIT, default 2, number of full-freeze cycles per instruction-RAM data access (1..15); CNT_W, default 16, statistics counter width.
REQ-002 SHALL have ports: CLK  in  1  rising-edge clock; RST  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: idRx, idRy  in  3 each  source register fields of the instruction in ID; idUsesRx, idUsesRy  in  1 each  source actually read.
REQ-004 SHALL have ports: exMemRead  in  2  ID/EX-stage memory read type (0 = none); exRegWrite  in  1; exDstReg  in  3  resolved EX destination.
REQ-005 SHALL have ports: exBranchTaken, exJump  in  1 each  EX redirect; memInstrSpace  in  1  MEM stage accesses instruction RAM this cycle.
REQ-006 SHALL have ports: pcWrite, ifidWrite  out  1 each; ifidFlush, idexBubble  out  1 each; idexHold, exmemHold  out  1 each.
REQ-007 SHALL have ports (HAZARD_STATS_EN only): stallCount, flushCount, freezeCount  out  CNT_W each.

Function
REQ-008 SHALL implement FSM states RUN and FREEZE plus a 4-bit wait counter.
REQ-009 SHALL drive all control outputs combinationally from current state and inputs; no added latency.
REQ-010 Load-use SHALL be: exMemRead != 0 and exRegWrite and ((idUsesRx and idRx == exDstReg) or (idUsesRy and idRy == exDstReg)).
REQ-011 Redirect SHALL be: exBranchTaken or exJump.
REQ-012 In RUN with memInstrSpace = 1: SHALL enter FREEZE next edge, load counter with MEM_WAIT-1; in that cycle pcWrite = 0, ifidWrite = 0, idexHold = 1, exmemHold = 1, ifidFlush = 0, idexBubble = 0.
REQ-013 In FREEZE: same outputs as REQ-012; counter decrements each edge; SHALL return to RUN on the edge where counter = 0; total freeze length = MEM_WAIT cycles including the entry cycle.
REQ-014 Freeze SHALL take priority over redirect and load-use; those are evaluated only in RUN without memInstrSpace (held pipeline re-presents them after release).
REQ-015 In RUN, redirect, no freeze: pcWrite = 1, ifidWrite = 1, ifidFlush = 1, idexBubble = 1, holds = 0.
REQ-016 In RUN, load-use, no redirect, no freeze: pcWrite = 0, ifidWrite = 0, idexBubble = 1, ifidFlush = 0, holds = 0; exactly one bubble per load-use.
REQ-017 Redirect SHALL override load-use in the same cycle.
REQ-018 Otherwise: pcWrite = 1, ifidWrite = 1, all other outputs 0.
REQ-019 memInstrSpace asserted in FREEZE SHALL be ignored; re-evaluated in the first RUN cycle.
REQ-020 MEM_WAIT = 1 SHALL give a single freeze cycle without entering FREEZE.

Reset
REQ-021 RST = 1 SHALL immediately force state RUN, counter 0, statistics counters 0, regardless of CLK.
REQ-022 During reset outputs SHALL be pcWrite = 0, ifidWrite = 0, ifidFlush = 1, idexBubble = 1, holds = 0.
REQ-023 Reset asserted mid-FREEZE SHALL abort the freeze; first cycle after release behaves as RUN.

Configuration
REQ-024 With HAZARD_STATS_EN defined: stallCount +1 per load-use bubble cycle, flushCount +1 per redirect cycle, freezeCount +1 per freeze cycle; each saturates at all-ones.
REQ-025 Without HAZARD_STATS_EN: counters and their ports SHALL be absent; control behaviour identical.

Verification
REQ-026 idRx = 3, idUsesRx = 1, exMemRead = 1, exRegWrite = 1, exDstReg = 3 -> one cycle pcWrite = 0, ifidWrite = 0, idexBubble = 1; next cycle (exMemRead = 0) normal.
REQ-027 Same as REQ-026 plus exBranchTaken = 1 -> ifidFlush = 1, idexBubble = 1, pcWrite = 1.
REQ-028 MEM_WAIT = 3, memInstrSpace pulsed one cycle -> exactly 3 cycles pcWrite = 0, idexHold = exmemHold = 1, then normal.
REQ-029 exJump = 1 held through a 2-cycle freeze -> no flush during freeze, flush in first RUN cycle.
REQ-030 RST asserted in second freeze cycle -> outputs at reset values same cycle; after release memInstrSpace = 0 gives pcWrite = 1.
REQ-031 HAZARD_STATS_EN, CNT_W = 4, 20 load-use events -> stallCount = 15.
